jtag_uart_slave: RTL and testbench



---
 rtl/jtag_uart_pkg.sv | 16 +
 rtl/jtag_uart_slave_byte_fifo.sv | 37 +++
 rtl/jtag_uart_slave.sv | 118 +++++++++++
 tb/tb_jtag_uart_slave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_uart_pkg.sv
// jtag_uart_pkg: register map, bit positions and FSM encoding shared by the JTAG UART responder
package jtag_uart_pkg;
   localparam logic DATA_REG = 1'b0;
   localparam logic CTRL_REG = 1'b1;
   localparam int RVALID_BIT = 15;
   localparam int RE_BIT = 0;
   localparam int WE_BIT = 1;
   localparam int RI_BIT = 8;
   localparam int WI_BIT = 9;
   localparam int AC_BIT = 10;
   localparam int COUNT_LSB = 16;
   typedef enum logic {IDLE, RESP} state_t;
   function automatic logic [15:0] sat16(input logic [31:0] v);
      return (v > 32'h0000_ffff) ? 16'hffff : v[15:0];
   endfunction
endpackage

// File: rtl/jtag_uart_slave_byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through byte FIFO with occupancy count
module byte_fifo #(
   parameter int DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [7:0]                 din,
   output logic [7:0]                 dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_push = push & ~full;
   assign do_pop = pop & ~empty;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/jtag_uart_slave.sv
// jtag_uart_slave: Avalon-MM JTAG-UART data/control responder bridging the core to host TX/RX byte streams
module jtag_uart_slave
   import jtag_uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 64,
   parameter int WI_THRESH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        av_chipselect,
   input  logic        av_address,
   input  logic        av_read_n,
   input  logic        av_write_n,
   input  logic [31:0] av_writedata,
   output logic [31:0] av_readdata,
   output logic        av_waitrequest,
   output logic        irq,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   state_t state, next_state;
   logic req, is_wr, addr_q, wr_q, re, we, ac, ri, wi, ctrl_wr;
   logic [10:0] wdata_q;
   logic tx_push, tx_pop, tx_empty, tx_full, rx_push, rx_pop, rx_empty, rx_full;
   logic [7:0] rx_head;
   logic [CW-1:0] tx_count, rx_count;
   logic [15:0] wspace, ravail;
   logic [31:0] data_word, ctrl_word;
   logic unused_ok;
   assign req = av_chipselect & (~av_read_n | ~av_write_n);
   assign is_wr = av_read_n & ~av_write_n;
   assign wspace = sat16(32'(FIFO_DEPTH) - 32'(tx_count));
   assign ravail = sat16(32'(rx_count) - {31'd0, ~rx_empty});
   assign ri = ~rx_empty;
   assign wi = {16'd0, wspace} >= 32'(WI_THRESH);
   assign tx_valid = ~tx_empty;
   assign tx_pop = tx_valid & tx_ready;
   assign rx_ready = ~rx_full;
   assign rx_push = rx_valid & rx_ready;
   assign unused_ok = &{1'b0, av_writedata[31:11], tx_full};
   always_comb begin
      data_word = '0;
      data_word[7:0] = rx_empty ? 8'h00 : rx_head;
      data_word[RVALID_BIT] = ri;
      data_word[31:COUNT_LSB] = ravail;
      ctrl_word = '0;
      ctrl_word[RE_BIT] = re;
      ctrl_word[WE_BIT] = we;
      ctrl_word[RI_BIT] = ri;
      ctrl_word[WI_BIT] = wi;
      ctrl_word[AC_BIT] = ac;
      ctrl_word[31:COUNT_LSB] = wspace;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next_state;
   always_comb next_state = (state == IDLE && req) ? RESP : IDLE;
   // Side effects commit only in RESP, so an access aborted by reset leaves the FIFOs untouched
   always_comb begin
      av_waitrequest = ~rst & (state == IDLE) & req;
      tx_push = (state == RESP) & wr_q & (addr_q == DATA_REG);
      rx_pop = (state == RESP) & ~wr_q & (addr_q == DATA_REG) & ~rx_empty;
      ctrl_wr = (state == RESP) & wr_q & (addr_q == CTRL_REG);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         addr_q <= DATA_REG;
         wr_q <= 1'b0;
         wdata_q <= '0;
         av_readdata <= '0;
      end else if (state == IDLE && req) begin
         addr_q <= av_address;
         wr_q <= is_wr;
         wdata_q <= av_writedata[10:0];
         av_readdata <= (av_address == CTRL_REG) ? ctrl_word : data_word;
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         re <= 1'b0;
         we <= 1'b0;
         ac <= 1'b0;
         irq <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            re <= wdata_q[RE_BIT];
            we <= wdata_q[WE_BIT];
         end
         ac <= tx_pop | (ac & ~(ctrl_wr & wdata_q[AC_BIT]));
         irq <= (re & ri) | (we & wi);
      end
   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .din   (wdata_q[7:0]),
      .dout  (tx_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );
   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_data),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );
endmodule

// File: tb/tb_jtag_uart_slave.sv
// tb_jtag_uart_slave: directed and randomized checks of jtag_uart_slave against a queue-based model
module tb_jtag_uart_slave;
   logic clk = 1'b0;
   logic rst, cs, addr, read_n, write_n, wait_r, irq, tx_valid, tx_ready, rx_valid, rx_ready;
   logic [31:0] wdata, rdata;
   logic [7:0] tx_data, rx_data;
   int passed = 0, total = 0;
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic m_re, m_we, m_ac;

   jtag_uart_slave dut (
      .clk            (clk),
      .rst            (rst),
      .av_chipselect  (cs),
      .av_address     (addr),
      .av_read_n      (read_n),
      .av_write_n     (write_n),
      .av_writedata   (wdata),
      .av_readdata    (rdata),
      .av_waitrequest (wait_r),
      .irq            (irq),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_data();
      if (rx_q.size() == 0) return 32'h0;
      return {16'(rx_q.size() - 1), 1'b1, 7'h0, rx_q[0]};
   endfunction

   function automatic logic [31:0] exp_ctrl();
      int sp = 64 - tx_q.size();
      return {16'(sp), 5'h0, m_ac, sp >= 8, rx_q.size() != 0, 6'h0, m_we, m_re};
   endfunction

   function automatic logic exp_irq();
      return (m_re && rx_q.size() != 0) || (m_we && (64 - tx_q.size()) >= 8);
   endfunction

   task automatic access(input logic a, input logic w, input logic [31:0] d, output logic [31:0] q, output int ws);
      @(negedge clk);
      cs = 1'b1; addr = a; read_n = w; write_n = !w; wdata = d;
      ws = 0;
      #1;
      while (wait_r && ws < 8) begin
         @(negedge clk);
         #1;
         ws++;
      end
      q = rdata;
      @(posedge clk);
   endtask

   task automatic release_bus();
      @(negedge clk);
      cs = 1'b0; read_n = 1'b1; write_n = 1'b1;
   endtask

   task automatic core_write(input logic a, input logic [31:0] d, input string name);
      logic [31:0] q;
      int ws;
      access(a, 1'b1, d, q, ws);
      total++;
      if (ws !== 1) $display("FAIL %s_wait: got %0d wait cycles, expected 1", name, ws);
      else passed++;
      if (a == 1'b0) begin
         if (tx_q.size() < 64) tx_q.push_back(d[7:0]);
      end else begin
         m_re = d[0];
         m_we = d[1];
         if (d[10]) m_ac = 1'b0;
      end
   endtask

   task automatic core_read(input logic a, input logic [31:0] exp, input string name);
      logic [31:0] q;
      int ws;
      access(a, 1'b0, 32'h0, q, ws);
      total++;
      if (ws !== 1) $display("FAIL %s_wait: got %0d wait cycles, expected 1", name, ws);
      else passed++;
      total++;
      if (q !== exp) $display("FAIL %s: got %h, expected %h", name, q, exp);
      else passed++;
      if (a == 1'b0 && rx_q.size() != 0) void'(rx_q.pop_front());
   endtask

   task automatic host_push(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = b;
      #1;
      total++;
      if (rx_ready !== (rx_q.size() < 64)) $display("FAIL rx_ready: got %b, expected %b", rx_ready, rx_q.size() < 64);
      else passed++;
      if (rx_q.size() < 64) rx_q.push_back(b);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic host_drain(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tx_ready = 1'b1;
         #1;
         total++;
         if (tx_valid !== (tx_q.size() != 0)) $display("FAIL tx_valid: got %b, expected %b", tx_valid, tx_q.size() != 0);
         else passed++;
         if (tx_q.size() != 0) begin
            total++;
            if (tx_data !== tx_q[0]) $display("FAIL tx_data: got %h, expected %h", tx_data, tx_q[0]);
            else passed++;
            void'(tx_q.pop_front());
            m_ac = 1'b1;
         end
      end
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] q;
      int ws;
      repeat (2) @(negedge clk);
      total++;
      if ({wait_r, rdata, irq, tx_valid, rx_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset_outputs: got wr=%b rd=%h irq=%b txv=%b rxr=%b, expected 0 0 0 0 1", wait_r, rdata, irq, tx_valid, rx_ready);
      else passed++;
      rst = 1'b0;
      access(1'b1, 1'b0, 32'h0, q, ws);
      release_bus();
      total++;
      if (ws !== 1) $display("FAIL reset_ctrl_wait: got %0d, expected 1", ws);
      else passed++;
      total++;
      if (q !== 32'h0040_0200) $display("FAIL reset_ctrl_read: got %h, expected 00400200", q);
      else passed++;
      total++;
      if (irq !== 1'b0) $display("FAIL reset_irq: got %b, expected 0", irq);
      else passed++;
   endtask

   task automatic test_back_to_back();
      core_write(1'b0, 32'h41, "b2b_first");
      core_write(1'b0, 32'h42, "b2b_second");
      release_bus();
      host_drain(2);
      core_read(1'b1, 32'h0040_0600, "ac_set");
      core_write(1'b1, 32'h400, "ac_clear");
      core_read(1'b1, 32'h0040_0200, "ac_cleared");
      release_bus();
   endtask

   task automatic test_rx_read();
      host_push(8'h55);
      host_push(8'h66);
      core_read(1'b0, 32'h0001_8055, "rx_first");
      core_read(1'b0, 32'h0000_8066, "rx_second");
      core_read(1'b0, 32'h0000_0000, "rx_empty");
      release_bus();
   endtask

   task automatic test_tx_full();
      for (int i = 0; i < 64; i++) core_write(1'b0, 32'($urandom_range(0, 255)), "fill");
      core_write(1'b0, 32'h99, "fill_overflow");
      release_bus();
      core_read(1'b1, 32'h0000_0000, "full_ctrl");
      release_bus();
      host_drain(65);
   endtask

   task automatic test_irq();
      core_write(1'b1, 32'h1, "irq_enable");
      release_bus();
      host_push(8'h3c);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_rise_early: got %b, expected 0", irq);
      else passed++;
      @(negedge clk);
      total++;
      if (irq !== 1'b1) $display("FAIL irq_rise: got %b, expected 1", irq);
      else passed++;
      core_read(1'b0, 32'h0000_803c, "irq_pop");
      release_bus();
      total++;
      if (irq !== 1'b1) $display("FAIL irq_fall_early: got %b, expected 1", irq);
      else passed++;
      @(negedge clk);
      total++;
      if (irq !== 1'b0) $display("FAIL irq_fall: got %b, expected 0", irq);
      else passed++;
      core_write(1'b1, 32'h0, "irq_disable");
      release_bus();
   endtask

   task automatic test_random();
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 5))
            0: core_write(1'b0, $urandom, "rnd_wr_data");
            1: host_push(8'($urandom_range(0, 255)));
            2: core_read(1'b0, exp_data(), "rnd_rd_data");
            3: core_read(1'b1, exp_ctrl(), "rnd_rd_ctrl");
            4: core_write(1'b1, $urandom, "rnd_wr_ctrl");
            default: host_drain($urandom_range(1, 4));
         endcase
         release_bus();
         @(negedge clk);
         total++;
         if (irq !== exp_irq()) $display("FAIL rnd_irq: got %b, expected %b", irq, exp_irq());
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      host_push(8'ha5);
      core_write(1'b1, 32'h1, "mid_enable");
      release_bus();
      @(negedge clk);
      total++;
      if (irq !== 1'b1) $display("FAIL mid_irq_before: got %b, expected 1", irq);
      else passed++;
      @(negedge clk);
      cs = 1'b1; addr = 1'b0; read_n = 1'b0; write_n = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      total++;
      if ({wait_r, rdata, irq, tx_valid, rx_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1})
         $display("FAIL mid_reset_outputs: got wr=%b rd=%h irq=%b txv=%b rxr=%b, expected 0 0 0 0 1", wait_r, rdata, irq, tx_valid, rx_ready);
      else passed++;
      cs = 1'b0; read_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tx_q.delete(); rx_q.delete();
      m_re = 1'b0; m_we = 1'b0; m_ac = 1'b0;
      core_read(1'b0, 32'h0, "mid_rx_after");
      core_read(1'b1, 32'h0040_0200, "mid_ctrl_after");
      release_bus();
      @(negedge clk);
      cs = 1'b1; addr = 1'b0; read_n = 1'b1; write_n = 1'b0; wdata = 32'h77;
      @(posedge clk);
      #1;
      rst = 1'b1;
      cs = 1'b0; write_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (tx_valid !== 1'b0) $display("FAIL mid_no_push: got %b, expected 0", tx_valid);
      else passed++;
   endtask

   initial begin
      rst = 1'b1; cs = 1'b0; addr = 1'b0; read_n = 1'b1; write_n = 1'b1; wdata = 32'h0;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
      m_re = 1'b0; m_we = 1'b0; m_ac = 1'b0;
      test_reset();
      test_back_to_back();
      test_rx_read();
      test_tx_full();
      test_irq();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
